// File: rtl/ex_fu_result_collector_pkg.sv
// ex_fu_result_collector_pkg: opcodes, multi-cycle class indices, FSM states, sizing helpers.
// Rev 1.0
`default_nettype none

package ex_fu_result_collector_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  // 4'h9 is reserved and decodes as an ALU-class op
  localparam logic [3:0] ALU_MUL  = 4'hA;
  localparam logic [3:0] ALU_MULH = 4'hB;
  localparam logic [3:0] ALU_DIV  = 4'hC;
  localparam logic [3:0] ALU_DIVU = 4'hD;
  localparam logic [3:0] ALU_REM  = 4'hE;
  localparam logic [3:0] ALU_REMU = 4'hF;

  localparam int MC_MUL = 0;
  localparam int MC_DIV = 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_fu_result_collector_if.sv
// ex_fu_result_collector_if: EX-stage op/result bus between pipeline, units and collector.
// Rev 1.0
`default_nettype none

interface ex_fu_result_collector_if #(
  parameter int XLEN   = 32,
  parameter int OP_W   = 4,
  parameter int NUM_MC = 2
);
  logic                     ex_valid;
  logic                     flush;
  logic [OP_W-1:0]          alu_op;
  logic [XLEN-1:0]          alu_result;
  logic [NUM_MC-1:0]        fu_start;
  logic [NUM_MC-1:0]        fu_kill;
  logic [NUM_MC-1:0]        fu_done;
  logic [NUM_MC*XLEN-1:0]   fu_result;
  logic                     ex_stall;
  logic                     res_valid;
  logic [XLEN-1:0]          res_data;
  logic                     ex_err;

  modport master (
    output ex_valid, flush, alu_op, alu_result, fu_done, fu_result,
    input  fu_start, fu_kill, ex_stall, res_valid, res_data, ex_err
  );

  modport slave (
    input  ex_valid, flush, alu_op, alu_result, fu_done, fu_result,
    output fu_start, fu_kill, ex_stall, res_valid, res_data, ex_err
  );
endinterface

`default_nettype wire

// File: rtl/ex_fu_result_collector_op_class.sv
// ex_op_class: decodes alu_op into {is_mc, mc_idx}; anything not multi-cycle is ALU-class.
// Rev 1.0
`default_nettype none

module ex_op_class
  import ex_fu_result_collector_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int IDX_W = 1
) (
  input  logic [OP_W-1:0]  alu_op,
  output logic             is_mc,
  output logic [IDX_W-1:0] mc_idx
);

  always_comb begin
    is_mc  = 1'b0;
    mc_idx = '0;
    case (alu_op)
      ALU_MUL, ALU_MULH: begin
        is_mc  = 1'b1;
        mc_idx = IDX_W'(MC_MUL);
      end
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: begin
        is_mc  = 1'b1;
        mc_idx = IDX_W'(MC_DIV);
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ex_fu_result_collector.sv
// ex_fu_result_collector: issues multi-cycle ops, stalls EX, registers ALU/unit result.
// Rev 1.0 -- optional watchdog abort enabled by EX_MC_TIMEOUT_EN.
`default_nettype none

module ex_fu_result_collector
  import ex_fu_result_collector_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int OP_W        = 4,
  parameter int NUM_MC      = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  ex_fu_result_collector_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_MC);

  state_t              state;
  logic [IDX_W-1:0]    mc_idx_q;
  logic [IDX_W-1:0]    dec_idx;
  logic                dec_is_mc;
  logic [NUM_MC-1:0]   start_q;
  logic [NUM_MC-1:0]   kill_q;
  logic                valid_q;
  logic [XLEN-1:0]     data_q;
  logic [XLEN-1:0]     sel_result;
  logic                sel_done;
  logic                issue;

  ex_op_class #(
    .OP_W  (OP_W),
    .IDX_W (IDX_W)
  ) u_op_class (
    .alu_op (bus.alu_op),
    .is_mc  (dec_is_mc),
    .mc_idx (dec_idx)
  );

  // Only the unit latched at issue may complete the op.
  always_comb begin
    sel_done   = 1'b0;
    sel_result = '0;
    for (int k = 0; k < NUM_MC; k++) begin
      if (mc_idx_q == IDX_W'(k)) begin
        sel_done   = bus.fu_done[k];
        sel_result = bus.fu_result[k*XLEN +: XLEN];
      end
    end
  end

  assign issue        = (state == ST_IDLE) && bus.ex_valid && !bus.flush;
  assign bus.ex_stall = (state == ST_IDLE) ? (issue && dec_is_mc) : !sel_done;

`ifdef EX_MC_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mc_idx_q <= '0;
      start_q  <= '0;
      kill_q   <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
`ifdef EX_MC_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      start_q <= '0;
      kill_q  <= '0;
      valid_q <= 1'b0;
`ifdef EX_MC_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (issue) begin
            if (dec_is_mc) begin
              start_q  <= NUM_MC'(1) << dec_idx;
              mc_idx_q <= dec_idx;
              state    <= ST_WAIT;
`ifdef EX_MC_TIMEOUT_EN
              cnt_q    <= '0;
`endif
            end else begin
              data_q  <= bus.alu_result;
              valid_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          // Flush beats a same-cycle done: the killed op must not retire.
          if (bus.flush) begin
            kill_q <= NUM_MC'(1) << mc_idx_q;
            state  <= ST_IDLE;
          end else if (sel_done) begin
            data_q  <= sel_result;
            valid_q <= 1'b1;
            state   <= ST_IDLE;
`ifdef EX_MC_TIMEOUT_EN
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            kill_q  <= NUM_MC'(1) << mc_idx_q;
            data_q  <= '0;
            valid_q <= 1'b1;
            err_q   <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.fu_start  = start_q;
  assign bus.fu_kill   = kill_q;
  assign bus.res_valid = valid_q;
  assign bus.res_data  = data_q;
`ifdef EX_MC_TIMEOUT_EN
  assign bus.ex_err    = err_q;
`else
  assign bus.ex_err    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_fu_result_collector.sv
// tb_ex_fu_result_collector: directed stimulus with a result scoreboard for ex_fu_result_collector.
// Rev 1.0
`default_nettype none

module tb_ex_fu_result_collector;
  import ex_fu_result_collector_pkg::*;

  localparam int XLEN = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [XLEN-1:0] exp_q[$];

  ex_fu_result_collector_if #(.XLEN(XLEN), .OP_W(4), .NUM_MC(2)) bus ();

  ex_fu_result_collector #(
    .XLEN        (XLEN),
    .OP_W        (4),
    .NUM_MC      (2),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [XLEN-1:0] res);
    bus.ex_valid   = 1'b1;
    bus.alu_op     = op;
    bus.alu_result = res;
  endtask

  // Scoreboard: every result pulse must match the oldest expected value.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.res_valid === 1'b1) begin
      chk("res_valid_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("sb_res_data", 64'(bus.res_data), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (observed=running expected=finished)");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]      ops  [4];
    logic [XLEN-1:0] vals [4];
    checks = 0;
    errors = 0;
    ops  = '{ALU_XOR, ALU_SLT, 4'h9, ALU_SRA};
    vals = '{32'hA5A5_5A5A, 32'h0000_0001, 32'h0000_1234, 32'h8000_0000};

    rst            = 1'b1;
    bus.ex_valid   = 1'b0;
    bus.flush      = 1'b0;
    bus.alu_op     = ALU_ADD;
    bus.alu_result = '0;
    bus.fu_done    = '0;
    bus.fu_result  = '0;
    cyc();
    cyc();
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res_data",  64'(bus.res_data),  64'd0);
    chk("rst_fu_start",  64'(bus.fu_start),  64'd0);
    chk("rst_fu_kill",   64'(bus.fu_kill),   64'd0);
    chk("rst_ex_err",    64'(bus.ex_err),    64'd0);
    rst = 1'b0;

    // ALU op, latency 1, never stalls
    cyc();
    drive_op(ALU_ADD, 32'h0000_0007);
    exp_q.push_back(32'h0000_0007);
    #1 chk("alu_add_stall", 64'(bus.ex_stall), 64'd0);
    cyc();
    bus.ex_valid = 1'b0;
    #1 chk("alu_add_valid", 64'(bus.res_valid), 64'd1);
    chk("alu_add_data", 64'(bus.res_data), 64'h7);

    // Back-to-back ALU-class ops including the reserved opcode
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive_op(ops[i], vals[i]);
      exp_q.push_back(vals[i]);
      #1 chk("alu_seq_stall", 64'(bus.ex_stall), 64'd0);
    end
    cyc();
    bus.ex_valid = 1'b0;
    #1 chk("alu_seq_last_data", 64'(bus.res_data), 64'h8000_0000);

    // Flush in IDLE drops a multi-cycle op
    cyc();
    drive_op(ALU_MUL, 32'h0);
    bus.flush = 1'b1;
    #1 chk("idle_flush_stall", 64'(bus.ex_stall), 64'd0);
    cyc();
    bus.ex_valid = 1'b0;
    bus.flush    = 1'b0;
    #1 chk("idle_flush_start", 64'(bus.fu_start), 64'd0);
    chk("idle_flush_valid", 64'(bus.res_valid), 64'd0);

    // Stray done in IDLE
    cyc();
    bus.fu_done   = 2'b11;
    bus.fu_result = {32'h1111_1111, 32'h2222_2222};
    #1 chk("idle_done_stall", 64'(bus.ex_stall), 64'd0);
    cyc();
    bus.fu_done = 2'b00;
    #1 chk("idle_done_valid", 64'(bus.res_valid), 64'd0);

    // MUL: done three cycles after start; op stays presented while stalled
    cyc();
    drive_op(ALU_MUL, 32'hDEAD_BEEF);
    #1 chk("mul_issue_stall", 64'(bus.ex_stall), 64'd1);
    cyc();
    #1 chk("mul_start", 64'(bus.fu_start), 64'b01);
    chk("mul_wait1_stall", 64'(bus.ex_stall), 64'd1);
    cyc();
    #1 chk("mul_start_pulse", 64'(bus.fu_start), 64'b00);
    chk("mul_wait2_stall", 64'(bus.ex_stall), 64'd1);
    cyc();
    #1 chk("mul_wait3_stall", 64'(bus.ex_stall), 64'd1);
    cyc();
    bus.fu_done   = 2'b01;
    bus.fu_result = {32'h0000_0000, 32'hFFFF_FFFE};
    exp_q.push_back(32'hFFFF_FFFE);
    #1 chk("mul_done_stall", 64'(bus.ex_stall), 64'd0);
    cyc();
    bus.fu_done  = 2'b00;
    bus.ex_valid = 1'b0;
    #1 chk("mul_res_valid", 64'(bus.res_valid), 64'd1);
    chk("mul_res_data", 64'(bus.res_data), 64'hFFFF_FFFE);
    cyc();
    #1 chk("mul_no_reissue", 64'(bus.fu_start), 64'd0);
    chk("mul_valid_pulse", 64'(bus.res_valid), 64'd0);

    // DIV: wrong-unit done ignored, then the right one
    cyc();
    drive_op(ALU_DIV, 32'h0);
    cyc();
    bus.ex_valid = 1'b0;
    #1 chk("div_start", 64'(bus.fu_start), 64'b10);
    cyc();
    bus.fu_done   = 2'b01;
    bus.fu_result = {32'h0000_0000, 32'hDEAD_0000};
    #1 chk("div_wrong_done_stall", 64'(bus.ex_stall), 64'd1);
    cyc();
    bus.fu_done = 2'b00;
    #1 chk("div_wrong_done_valid", 64'(bus.res_valid), 64'd0);
    chk("div_still_stalled", 64'(bus.ex_stall), 64'd1);
    cyc();
    bus.fu_done   = 2'b10;
    bus.fu_result = {32'h0000_0015, 32'hDEAD_0000};
    exp_q.push_back(32'h0000_0015);
    #1 chk("div_done_stall", 64'(bus.ex_stall), 64'd0);
    cyc();
    bus.fu_done = 2'b00;
    #1 chk("div_res_valid", 64'(bus.res_valid), 64'd1);
    chk("div_res_data", 64'(bus.res_data), 64'h15);

    // DIV: flush and done together, flush wins
    cyc();
    drive_op(ALU_REM, 32'h0);
    cyc();
    bus.ex_valid  = 1'b0;
    cyc();
    bus.flush     = 1'b1;
    bus.fu_done   = 2'b10;
    bus.fu_result = {32'h0000_0BAD, 32'h0};
    cyc();
    bus.flush   = 1'b0;
    bus.fu_done = 2'b00;
    drive_op(ALU_ADD, 32'h0000_0099);
    exp_q.push_back(32'h0000_0099);
    #1 chk("flush_kill", 64'(bus.fu_kill), 64'b10);
    chk("flush_no_valid", 64'(bus.res_valid), 64'd0);
    chk("flush_idle_stall", 64'(bus.ex_stall), 64'd0);
    cyc();
    bus.ex_valid = 1'b0;
    #1 chk("flush_kill_pulse", 64'(bus.fu_kill), 64'd0);
    chk("post_flush_alu", 64'(bus.res_data), 64'h99);

    // Reset two cycles into a MUL wait
    cyc();
    drive_op(ALU_MULH, 32'h0);
    cyc();
    bus.ex_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1 chk("midrst_start", 64'(bus.fu_start), 64'd0);
    chk("midrst_kill",   64'(bus.fu_kill),   64'd0);
    chk("midrst_valid",  64'(bus.res_valid), 64'd0);
    chk("midrst_data",   64'(bus.res_data),  64'd0);
    chk("midrst_err",    64'(bus.ex_err),    64'd0);
    drive_op(ALU_ADD, 32'h0000_0042);
    exp_q.push_back(32'h0000_0042);
    #1 chk("midrst_stall", 64'(bus.ex_stall), 64'd0);
    cyc();
    bus.ex_valid = 1'b0;
    #1 chk("midrst_alu_valid", 64'(bus.res_valid), 64'd1);
    chk("midrst_alu_data", 64'(bus.res_data), 64'h42);

`ifdef EX_MC_TIMEOUT_EN
    // Watchdog: DIV never completes
    cyc();
    drive_op(ALU_DIVU, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      bus.ex_valid = 1'b0;
      if (k == 8) exp_q.push_back(32'h0);
      #1 chk("to_wait_stall", 64'(bus.ex_stall), 64'd1);
      chk("to_wait_valid", 64'(bus.res_valid), 64'd0);
    end
    cyc();
    #1 chk("to_kill", 64'(bus.fu_kill), 64'b10);
    chk("to_err",   64'(bus.ex_err),    64'd1);
    chk("to_valid", 64'(bus.res_valid), 64'd1);
    chk("to_data",  64'(bus.res_data),  64'd0);
    cyc();
    #1 chk("to_err_pulse", 64'(bus.ex_err), 64'd0);
    chk("to_kill_pulse", 64'(bus.fu_kill), 64'd0);
`endif

    cyc();
    cyc();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
